// File: rtl/reg_writeback.sv
// Register file write-port master: merges pipeline WB writes with queued MDU results.
// Pipeline writes always win; MDU results drain from a small FIFO into idle slots.
module reg_writeback #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_wen,
  input  logic [4:0]               pipe_addr,
  input  logic [31:0]              pipe_data,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_addr,
  input  logic [31:0]              mdu_data,
  input  logic [4:0]               r1A,
  input  logic [4:0]               r2A,
  output logic                     pend1,
  output logic                     pend2,
  output logic                     regW,
  output logic [4:0]               wrA,
  output logic [31:0]              wrD,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] kill_q;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic [AW-1:0]    offs [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             pipe_eff;
  logic             empty;
  logic             pop;
  logic             store;

  assign pipe_eff   = pipe_wen && (pipe_addr != 5'd0);
  assign empty      = (count == CW'(0));
  assign pop        = !pipe_eff && !empty;
  assign mdu_ready  = !rst && (count < CW'(DEPTH));
  assign store      = mdu_valid && mdu_ready && (mdu_addr != 5'd0);
  assign fifo_count = count;

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs[i]  = AW'(i) - rd_ptr;
      valid[i] = ({1'b0, offs[i]} < count);
    end
  end

  // Scoreboard lookup over queued, non-killed entries; r0 is never pending.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && !kill_q[i] && (addr_q[i] == r1A)) pend1 = 1'b1;
      if (valid[i] && !kill_q[i] && (addr_q[i] == r2A)) pend2 = 1'b1;
    end
    if (r1A == 5'd0) pend1 = 1'b0;
    if (r2A == 5'd0) pend2 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regW   <= 1'b0;
      wrA    <= 5'd0;
      wrD    <= 32'd0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      kill_q <= '0;
    end else begin
      if (pipe_eff) begin
        regW <= 1'b1;
        wrA  <= pipe_addr;
        wrD  <= pipe_data;
      end else if (pop && !kill_q[rd_ptr]) begin
        regW <= 1'b1;
        wrA  <= addr_q[rd_ptr];
        wrD  <= data_q[rd_ptr];
      end else begin
        regW <= 1'b0;
      end

      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (store) wr_ptr <= wr_ptr + AW'(1);
      count <= count + CW'(store) - CW'(pop);

      // A younger pipe write supersedes every older queued result to the same register.
      if (pipe_eff) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid[i] && (addr_q[i] == pipe_addr)) kill_q[i] <= 1'b1;
        end
      end
      if (store) kill_q[wr_ptr] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      addr_q[wr_ptr] <= mdu_addr;
      data_q[wr_ptr] <= mdu_data;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reg_writeback;

  localparam int unsigned DEPTH = 4;

  logic        clk, rst;
  logic        pipe_wen, mdu_valid, mdu_ready;
  logic [4:0]  pipe_addr, mdu_addr, r1A, r2A, wrA;
  logic [31:0] pipe_data, mdu_data, wrD;
  logic        pend1, pend2, regW;
  logic [2:0]  fifo_count;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .r1A(r1A), .r2A(r2A), .pend1(pend1), .pend2(pend2),
    .regW(regW), .wrA(wrA), .wrD(wrD), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of queued results with a superseded flag.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          k;
  } ent_t;

  ent_t        q[$];
  bit          started = 0;
  logic        m_regW;
  logic [4:0]  m_wrA;
  logic [31:0] m_wrD;

  function automatic bit mpend(input logic [4:0] a);
    bit r = 0;
    if (a != 5'd0)
      foreach (q[i]) if (q[i].a == a && !q[i].k) r = 1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_regW = 1'b0; m_wrA = 5'd0; m_wrD = 32'd0;
      started = 1;
    end else if (started) begin
      bit   rdy;
      ent_t h;
      ent_t n;
      rdy = (q.size() < DEPTH);
      if (pipe_wen && pipe_addr != 5'd0) begin
        m_regW = 1'b1; m_wrA = pipe_addr; m_wrD = pipe_data;
        foreach (q[i]) if (q[i].a == pipe_addr) q[i].k = 1;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        if (!h.k) begin m_regW = 1'b1; m_wrA = h.a; m_wrD = h.d; end
        else m_regW = 1'b0;
      end else begin
        m_regW = 1'b0;
      end
      if (mdu_valid && rdy && mdu_addr != 5'd0) begin
        n.a = mdu_addr; n.d = mdu_data; n.k = 0;
        q.push_back(n);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("cmp_regW", 32'(regW), 32'(m_regW));
      chk("cmp_wrA", 32'(wrA), 32'(m_wrA));
      chk("cmp_wrD", wrD, m_wrD);
      chk("cmp_count", 32'(fifo_count), 32'(q.size()));
      chk("cmp_ready", 32'(mdu_ready), 32'(!rst && q.size() < DEPTH));
      chk("cmp_pend1", 32'(pend1), 32'(mpend(r1A)));
      chk("cmp_pend2", 32'(pend2), 32'(mpend(r2A)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    pipe_wen = 0; pipe_addr = 0; pipe_data = 0;
    mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
  endtask

  initial begin
    rst = 1; r1A = 0; r2A = 0;
    idle();

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      pipe_wen = 1'($urandom); pipe_addr = 5'($urandom); pipe_data = $urandom;
      mdu_valid = 1'($urandom); mdu_addr = 5'($urandom); mdu_data = $urandom;
      cyc();
    end
    chk("rst_regW", 32'(regW), 32'd0);
    chk("rst_wrA", 32'(wrA), 32'd0);
    chk("rst_wrD", wrD, 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(mdu_ready), 32'd0);
    idle();
    rst = 0;
    #1;
    chk("rel_ready", 32'(mdu_ready), 32'd1);
    cyc();

    // Pipe write, then a write to r0
    pipe_wen = 1; pipe_addr = 5; pipe_data = 32'hDEADBEEF;
    cyc();
    idle();
    chk("pipe_regW", 32'(regW), 32'd1);
    chk("pipe_wrA", 32'(wrA), 32'd5);
    chk("pipe_wrD", wrD, 32'hDEADBEEF);
    cyc();
    chk("pipe_idle_regW", 32'(regW), 32'd0);
    chk("pipe_hold_wrA", 32'(wrA), 32'd5);
    pipe_wen = 1; pipe_addr = 0; pipe_data = 32'h11112222;
    cyc();
    idle();
    chk("r0_regW", 32'(regW), 32'd0);
    chk("r0_hold_wrD", wrD, 32'hDEADBEEF);
    cyc();

    // MDU result waits behind three pipe writes
    r1A = 9;
    pipe_wen = 1; pipe_addr = 3; pipe_data = 32'h0;
    mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h12345678;
    cyc();
    mdu_valid = 0;
    chk("mdu_pend_a", 32'(pend1), 32'd1);
    chk("mdu_count", 32'(fifo_count), 32'd1);
    pipe_data = 32'h1;
    cyc();
    chk("mdu_pend_b", 32'(pend1), 32'd1);
    pipe_data = 32'h2;
    cyc();
    chk("mdu_pend_c", 32'(pend1), 32'd1);
    chk("mdu_pipe_wrA", 32'(wrA), 32'd3);
    idle();
    cyc();
    chk("mdu_regW", 32'(regW), 32'd1);
    chk("mdu_wrA", 32'(wrA), 32'd9);
    chk("mdu_wrD", wrD, 32'h12345678);
    chk("mdu_pend_off", 32'(pend1), 32'd0);
    r1A = 0;
    cyc();

    // Fill the FIFO behind a busy pipe, then drain in order
    pipe_wen = 1; pipe_addr = 20; pipe_data = 32'hCAFE0000;
    for (int a = 1; a <= 4; a++) begin
      mdu_valid = 1; mdu_addr = 5'(a); mdu_data = 32'h100 + 32'(a);
      cyc();
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(mdu_ready), 32'd0);
    mdu_addr = 5; mdu_data = 32'h105;
    cyc();
    chk("full_reject", 32'(fifo_count), 32'd4);
    idle();
    for (int a = 1; a <= 4; a++) begin
      cyc();
      chk("drain_regW", 32'(regW), 32'd1);
      chk("drain_wrA", 32'(wrA), 32'(a));
      chk("drain_wrD", wrD, 32'h100 + 32'(a));
      chk("drain_count", 32'(fifo_count), 32'(4 - a));
    end
    chk("drain_ready", 32'(mdu_ready), 32'd1);
    cyc();

    // WAW kill: queued r8 superseded by a later pipe write
    r2A = 8;
    pipe_wen = 1; pipe_addr = 21; pipe_data = 32'h0;
    mdu_valid = 1; mdu_addr = 8; mdu_data = 32'hAAAA0000;
    cyc();
    mdu_valid = 0;
    pipe_addr = 8; pipe_data = 32'hBBBB0000;
    #1;
    chk("waw_pend_pre", 32'(pend2), 32'd1);
    cyc();
    idle();
    chk("waw_pend_post", 32'(pend2), 32'd0);
    chk("waw_regW", 32'(regW), 32'd1);
    chk("waw_wrA", 32'(wrA), 32'd8);
    chk("waw_wrD", wrD, 32'hBBBB0000);
    chk("waw_count", 32'(fifo_count), 32'd1);
    cyc();
    chk("waw_discard", 32'(regW), 32'd0);
    chk("waw_discard_count", 32'(fifo_count), 32'd0);
    chk("waw_keep_wrD", wrD, 32'hBBBB0000);
    cyc();

    // Push and pipe write to r8 in the same cycle: pipe first, then MDU
    pipe_wen = 1; pipe_addr = 8; pipe_data = 32'hCCCC0000;
    mdu_valid = 1; mdu_addr = 8; mdu_data = 32'hDDDD0000;
    cyc();
    idle();
    chk("same_wrD1", wrD, 32'hCCCC0000);
    chk("same_pend", 32'(pend2), 32'd1);
    cyc();
    chk("same_regW2", 32'(regW), 32'd1);
    chk("same_wrA2", 32'(wrA), 32'd8);
    chk("same_wrD2", wrD, 32'hDDDD0000);
    r2A = 0;
    cyc();

    // Reset in the middle of a drain
    pipe_wen = 1; pipe_addr = 22; pipe_data = 32'h0;
    for (int a = 10; a <= 12; a++) begin
      mdu_valid = 1; mdu_addr = 5'(a); mdu_data = 32'h200 + 32'(a);
      cyc();
    end
    idle();
    r1A = 11; r2A = 12;
    cyc();
    chk("mid_wrA", 32'(wrA), 32'd10);
    chk("mid_count", 32'(fifo_count), 32'd2);
    rst = 1; mdu_valid = 1; mdu_addr = 13; mdu_data = 32'h213;
    cyc();
    idle();
    rst = 0;
    chk("mid_rst_regW", 32'(regW), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_pend1", 32'(pend1), 32'd0);
    chk("mid_rst_pend2", 32'(pend2), 32'd0);
    cyc();
    chk("mid_after_regW", 32'(regW), 32'd0);
    chk("mid_after_count", 32'(fifo_count), 32'd0);

    // Mixed traffic over a small register range to stress kills and ordering
    for (int i = 0; i < 200; i++) begin
      pipe_wen  = ($urandom_range(0, 2) == 0);
      pipe_addr = 5'($urandom_range(0, 7));
      pipe_data = $urandom;
      mdu_valid = 1'($urandom);
      mdu_addr  = 5'($urandom_range(0, 7));
      mdu_data  = $urandom;
      r1A       = 5'($urandom_range(0, 7));
      r2A       = 5'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 63) == 0);
      cyc();
    end
    idle();
    rst = 0;
    repeat (6) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
